// File: rtl/updown_counter_gen.sv
// updown_counter_gen: bounded up-wrap / down-wrap / bounce counter with clamped load and a bound-error guard.
// Optional feature: `define UPDOWN_COUNTER_SATURATE_EN adds input sat (saturate instead of wrap in modes 00/01).
module updown_counter_gen #(
  parameter int WIDTH      = 8,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      lo,
  input  logic [WIDTH-1:0]      hi,
  input  logic [STEP_WIDTH-1:0] step,
`ifdef UPDOWN_COUNTER_SATURATE_EN
  input  logic                  sat,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  dir,
  output logic                  wrap,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    MODE_DOWN   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // The bounce FSM state is the direction bit itself.
  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } bounce_e;

  bounce_e          dir_q;
  logic [WIDTH-1:0] step_w;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   lo_plus_step;
  logic [WIDTH-1:0] count_dn;
  logic [WIDTH-1:0] load_clamped;
  logic             bad_cfg;
  logic             step_zero;
  logic             sat_on;

`ifdef UPDOWN_COUNTER_SATURATE_EN
  assign sat_on = sat;
`else
  assign sat_on = 1'b0;
`endif

  assign dir = dir_q;

  // Comparisons use one extra bit so count+step and lo+step never alias back into range.
  always_comb begin
    step_w       = WIDTH'(step);
    up_sum       = {1'b0, count} + {1'b0, step_w};
    lo_plus_step = {1'b0, lo} + {1'b0, step_w};
    count_dn     = count - step_w;
    bad_cfg      = (hi < lo);
    step_zero    = (step == '0);
    if (load_val < lo) begin
      load_clamped = lo;
    end else if (load_val > hi) begin
      load_clamped = hi;
    end else begin
      load_clamped = load_val;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      dir_q   <= UP;
      wrap    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= bad_cfg;
      wrap    <= 1'b0;
      if (!bad_cfg) begin
        if (load) begin
          count <= load_clamped;
        end else if (en) begin
          unique case (mode_e'(mode))
            MODE_UP: begin
              dir_q <= UP;
              if (!step_zero) begin
                if (up_sum > {1'b0, hi}) begin
                  if (sat_on) begin
                    count <= hi;
                  end else begin
                    count <= lo;
                    wrap  <= 1'b1;
                  end
                end else begin
                  count <= up_sum[WIDTH-1:0];
                end
              end
            end
            MODE_DOWN: begin
              dir_q <= DOWN;
              if (!step_zero) begin
                if ({1'b0, count} < lo_plus_step) begin
                  if (sat_on) begin
                    count <= lo;
                  end else begin
                    count <= hi;
                    wrap  <= 1'b1;
                  end
                end else begin
                  count <= count_dn;
                end
              end
            end
            MODE_BOUNCE: begin
              if (!step_zero) begin
                if (dir_q == UP) begin
                  if (up_sum >= {1'b0, hi}) begin
                    count <= hi;
                    dir_q <= DOWN;
                    wrap  <= 1'b1;
                  end else begin
                    count <= up_sum[WIDTH-1:0];
                  end
                end else begin
                  if ({1'b0, count} <= lo_plus_step) begin
                    count <= lo;
                    dir_q <= UP;
                    wrap  <= 1'b1;
                  end else begin
                    count <= count_dn;
                  end
                end
              end
            end
            MODE_HOLD: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_gen.sv
// Scoreboard bench for updown_counter_gen: directed scenarios with fixed expectations, then random stimulus
// against an integer reference model. Define UPDOWN_COUNTER_SATURATE_EN to also exercise the sat port.
module tb_updown_counter_gen;
  localparam int W  = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic          sat = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  lo = '0;
  logic [W-1:0]  hi = '0;
  logic [SW-1:0] step = '0;
  logic [W-1:0]  count;
  logic          dir;
  logic          wrap;
  logic          cfg_err;

  typedef struct packed {
    logic [W-1:0] count;
    logic         dir;
    logic         wrap;
    logic         cfg_err;
  } resp_t;

  resp_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    active = 1'b0;
  int    m_count = 0;
  int    m_dir = 1;

  always #5 clk = ~clk;

  updown_counter_gen #(.WIDTH(W), .STEP_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .lo(lo), .hi(hi), .step(step),
`ifdef UPDOWN_COUNTER_SATURATE_EN
    .sat(sat),
`endif
    .count(count), .dir(dir), .wrap(wrap), .cfg_err(cfg_err)
  );

  task automatic check(input string nm, input resp_t act, input resp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got count=%0d dir=%0b wrap=%0b cfg_err=%0b, expected count=%0d dir=%0b wrap=%0b cfg_err=%0b",
               nm, act.count, act.dir, act.wrap, act.cfg_err, exp.count, exp.dir, exp.wrap, exp.cfg_err);
    end
  endtask

  // Monitor: every active edge presents one response, compared against the oldest expectation.
  always @(posedge clk) begin
    if (active) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got an output with no expectation queued, required one");
      end else begin
        check(name_q.pop_front(), resp_t'({count, dir, wrap, cfg_err}), exp_q.pop_front());
      end
    end
  end

  task automatic tick(input string nm, input int c, input bit d, input bit w, input bit ce);
    resp_t r;
    r.count   = W'(c);
    r.dir     = d;
    r.wrap    = w;
    r.cfg_err = ce;
    exp_q.push_back(r);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input bit r, input bit e, input bit ld, input logic [1:0] md,
                        input logic [W-1:0] lv, input logic [W-1:0] l, input logic [W-1:0] h,
                        input logic [SW-1:0] st);
    rst = r; en = e; load = ld; mode = md; load_val = lv; lo = l; hi = h; step = st;
  endtask

  // Reference model: plain integer arithmetic straight from the behavioural rules.
  task automatic model_tick(input string nm);
    int c, s, l, h;
    bit w, ce, sat_eff;
    c = m_count; s = int'(step); l = int'(lo); h = int'(hi);
    w = 1'b0;
`ifdef UPDOWN_COUNTER_SATURATE_EN
    sat_eff = sat;
`else
    sat_eff = 1'b0;
`endif
    ce = (h < l);
    if (!rst) begin
      m_count = 0; m_dir = 1; ce = 1'b0;
    end else if (h < l) begin
      m_count = c;
    end else if (load) begin
      m_count = (int'(load_val) < l) ? l : (int'(load_val) > h) ? h : int'(load_val);
    end else if (en) begin
      case (mode)
        2'b01: begin
          m_dir = 1;
          if (s > 0) begin
            if (c + s > h) begin
              if (sat_eff) m_count = h;
              else begin m_count = l; w = 1'b1; end
            end else m_count = c + s;
          end
        end
        2'b00: begin
          m_dir = 0;
          if (s > 0) begin
            if (c - s < l) begin
              if (sat_eff) m_count = l;
              else begin m_count = h; w = 1'b1; end
            end else m_count = c - s;
          end
        end
        2'b10: begin
          if (s > 0) begin
            if (m_dir == 1) begin
              if (c + s >= h) begin m_count = h; m_dir = 0; w = 1'b1; end
              else m_count = c + s;
            end else begin
              if (c - s <= l) begin m_count = l; m_dir = 1; w = 1'b1; end
              else m_count = c - s;
            end
          end
        end
        default: m_count = c;
      endcase
    end
    tick(nm, m_count, m_dir[0], w, ce);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    active = 1'b1;

    set_in(0, 1, 1, 2'b01, 4'd5, 4'd2, 4'd9, 3'd3);
    tick("reset", 0, 1, 0, 0);

    // Up-wrap 2 -> 5 -> 8 -> 2 (wrap) -> 5.
    set_in(1, 1, 1, 2'b01, 4'd2, 4'd2, 4'd9, 3'd3);
    tick("up_load", 2, 1, 0, 0);
    load = 1'b0;
    tick("up_5", 5, 1, 0, 0);
    tick("up_8", 8, 1, 0, 0);
    tick("up_wrap", 2, 1, 1, 0);
    tick("up_after_wrap", 5, 1, 0, 0);

    // Down-wrap 3 -> 2 -> 9 (wrap) -> 8.
    load = 1'b1; load_val = 4'd3;
    tick("down_load", 3, 1, 0, 0);
    load = 1'b0; mode = 2'b00; step = 3'd1;
    tick("down_2", 2, 0, 0, 0);
    tick("down_wrap", 9, 0, 1, 0);
    tick("down_8", 8, 0, 0, 0);

    // Bounce over the full 4-bit range with step 4.
    set_in(1, 1, 1, 2'b00, 4'd0, 4'd0, 4'd15, 3'd4);
    tick("bnc_load", 0, 0, 0, 0);
    load = 1'b0; mode = 2'b01; step = 3'd0;
    tick("step0_up_dir", 0, 1, 0, 0);
    mode = 2'b10; step = 3'd4;
    tick("bnc_4", 4, 1, 0, 0);
    tick("bnc_8", 8, 1, 0, 0);
    tick("bnc_12", 12, 1, 0, 0);
    tick("bnc_top", 15, 0, 1, 0);
    tick("bnc_11", 11, 0, 0, 0);
    tick("bnc_7", 7, 0, 0, 0);
    tick("bnc_3", 3, 0, 0, 0);
    tick("bnc_bottom", 0, 1, 1, 0);
    tick("bnc_4b", 4, 1, 0, 0);
    step = 3'd0;
    tick("bnc_step0", 4, 1, 0, 0);
    mode = 2'b11; step = 3'd4;
    tick("hold_mode", 4, 1, 0, 0);
    en = 1'b0; mode = 2'b01;
    tick("en_low", 4, 1, 0, 0);

    // Clamped load, then inverted bounds freeze everything.
    set_in(1, 1, 1, 2'b01, 4'd12, 4'd2, 4'd9, 3'd3);
    tick("load_clamp_hi", 9, 1, 0, 0);
    load_val = 4'd0;
    tick("load_clamp_lo", 2, 1, 0, 0);
    hi = 4'd1;
    tick("cfg_err_set", 2, 1, 0, 1);
    load_val = 4'd5;
    tick("cfg_err_ignore_load", 2, 1, 0, 1);
    hi = 4'd9; load = 1'b0;
    tick("cfg_err_clear", 5, 1, 0, 0);

    // Reset mid-bounce while heading down, with load and en asserted.
    mode = 2'b10;
    tick("rb_8", 8, 1, 0, 0);
    tick("rb_top", 9, 0, 1, 0);
    tick("rb_6", 6, 0, 0, 0);
    rst = 1'b0; load = 1'b1; load_val = 4'd7;
    tick("rb_reset", 0, 1, 0, 0);
    rst = 1'b1; load = 1'b0;
    tick("rb_resume", 3, 1, 0, 0);

    // Count below a raised window recovers on the next down step.
    mode = 2'b00; step = 3'd1; lo = 4'd5; hi = 4'd6;
    tick("oor_recover", 6, 0, 1, 0);

`ifdef UPDOWN_COUNTER_SATURATE_EN
    set_in(1, 1, 1, 2'b01, 4'd15, 4'd0, 4'd15, 3'd1);
    sat = 1'b1;
    tick("sat_load", 15, 0, 0, 0);
    load = 1'b0;
    tick("sat_hold_top", 15, 1, 0, 0);
    sat = 1'b0;
    tick("sat_off_wrap", 0, 1, 1, 0);
`endif

    // Random phase: resync the model through a reset, then free-run.
    rst = 1'b0;
    model_tick("rand_reset");
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 20 == 0) begin
        a = W'($urandom_range(15));
        b = W'($urandom_range(15));
        if ($urandom_range(7) != 0 && b < a) begin lo = b; hi = a; end
        else begin lo = a; hi = b; end
      end
      rst      = ($urandom_range(99) != 0);
      load     = ($urandom_range(9) == 0);
      en       = ($urandom_range(7) != 0);
      mode     = 2'($urandom_range(3));
      step     = SW'($urandom_range(7));
      load_val = W'($urandom_range(15));
      sat      = ($urandom_range(1) == 1);
      model_tick("rand");
    end

    active = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_counter_gen.md
UPDOWN_COUNTER_GEN -- requirements
Module: updown_counter_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter and bound width in bits (>=2).
REQ-002 SHALL have parameter STEP_WIDTH, default 4: width of the step input (1..WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port en  input  1  count enable; when 0, count and dir hold.
REQ-006 SHALL have port mode  input  2  00 down-wrap, 01 up-wrap, 10 bounce, 11 hold.
REQ-007 SHALL have port load  input  1  synchronous load request.
REQ-008 SHALL have port load_val  input  WIDTH  value to load.
REQ-009 SHALL have port lo  input  WIDTH  inclusive lower bound, unsigned.
REQ-010 SHALL have port hi  input  WIDTH  inclusive upper bound, unsigned.
REQ-011 SHALL have port step  input  STEP_WIDTH  unsigned increment/decrement magnitude.
REQ-012 SHALL have port count  output  WIDTH  registered counter value.
REQ-013 SHALL have port dir  output  1  registered direction, 1 = up.
REQ-014 SHALL have port wrap  output  1  registered one-cycle pulse on wrap or bounce turnaround.
REQ-015 SHALL have port cfg_err  output  1  registered flag, high while hi < lo.

Function
REQ-016 Priority per edge SHALL be: reset, then cfg_err hold, then load, then en, then hold.
REQ-017 cfg_err SHALL be registered (hi < lo) every cycle; while (hi < lo), count and dir SHALL hold, load SHALL be ignored, and wrap SHALL be 0.
REQ-018 Load SHALL write load_val clamped to [lo,hi]: below lo -> lo, above hi -> hi. wrap = 0; dir unchanged.
REQ-019 All next-value arithmetic SHALL be unsigned in WIDTH+1 bits; no silent modulo-2^WIDTH overflow.
REQ-020 Up-wrap (mode 01), en=1: if count+step > hi then count <= lo and wrap <= 1, else count <= count+step; dir <= 1.
REQ-021 Down-wrap (mode 00), en=1: if count < lo+step then count <= hi and wrap <= 1, else count <= count-step; dir <= 0.
REQ-022 Bounce (mode 10) SHALL be a two-state FSM held in dir, with states UP and DOWN.
REQ-023 In UP: if count+step >= hi then count <= hi, dir <= 0 and wrap <= 1, else count <= count+step.
REQ-024 In DOWN: if count <= lo+step then count <= lo, dir <= 1 and wrap <= 1, else count <= count-step.
REQ-025 Hold (mode 11) SHALL keep count and dir; wrap = 0.
REQ-026 step = 0 SHALL leave count unchanged and wrap = 0 in every mode, including bounce.
REQ-027 A count left outside [lo,hi] by a bound change SHALL recover on the next enabled step via REQ-020/021/023/024.
REQ-028 wrap SHALL be 0 in every cycle not covered by REQ-020/021/023/024; a mode change takes effect on the same edge.

Reset
REQ-029 On rst = 0 at a rising edge, the block SHALL set count = 0, dir = 1, wrap = 0, cfg_err = 0, regardless of load and en.
REQ-030 Reset mid-bounce SHALL return the FSM to UP; the first post-reset step SHALL obey REQ-027.

Configuration
REQ-031 Macro UPDOWN_COUNTER_SATURATE_EN, when defined, SHALL add port sat  input  1.
REQ-032 With the macro defined and sat = 1, in modes 00/01 a step that would wrap SHALL instead set count to hi (up) or lo (down), with wrap = 0; bounce and hold are unaffected.
REQ-033 Without the macro, the sat port SHALL be absent and wrap behaviour per REQ-020/021 SHALL be unconditional.

Verification
REQ-034 WIDTH=4, lo=2, hi=9, step=3, mode=01, en=1, start 2 -> count 5, 8, then 2 with wrap=1 for exactly one cycle.
REQ-035 lo=2, hi=9, step=1, mode=00, start 3 -> count 2, then 9 with wrap=1, then 8.
REQ-036 lo=0, hi=15, step=4, mode=10, start 0 -> 4, 8, 12, 15 (dir->0, wrap), 11, 7, 3, 0 (dir->1, wrap), 4.
REQ-037 hi=9, lo=2: load=1, en=1, load_val=12 -> count 9, wrap 0; load_val=0 -> count 2; then hi=1 -> cfg_err=1 next cycle, count frozen.
REQ-038 Mid-count with load=1 and en=1, drive rst=0 for one edge -> count 0, dir 1, wrap 0; count resumes per REQ-027.
REQ-039 With UPDOWN_COUNTER_SATURATE_EN defined: sat=1, mode=01, lo=0, hi=15, step=1 at count 15 -> count stays 15, wrap 0; sat=0 -> 0 with wrap=1.
